// File: rtl/serv_dbus_pkg.sv
// Shared types and constants for the SERV serial data-bus adapter.
// Optional feature macro used by this slice: SERV_DBUS_MISALIGN_EN.
package serv_dbus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        WAIT = 2'd2
    } dbus_state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [5:0] W_BYTE = 6'd8;
    localparam logic [5:0] W_HALF = 6'd16;
    localparam logic [5:0] W_WORD = 6'd32;

    function automatic logic [1:0] size_enc(input logic word, input logic half);
        if (word) begin
            size_enc = SZ_WORD;
        end else if (half) begin
            size_enc = SZ_HALF;
        end else begin
            size_enc = SZ_BYTE;
        end
    endfunction

    function automatic logic [5:0] size_width(input logic [1:0] sz);
        case (sz)
            SZ_BYTE: size_width = W_BYTE;
            SZ_HALF: size_width = W_HALF;
            SZ_WORD: size_width = W_WORD;
            default: size_width = W_WORD;
        endcase
    endfunction

endpackage

// File: rtl/serv_dbus_lane.sv
// Byte-lane select, store-data replication and misalignment detect.
// Misalignment detection only exists when SERV_DBUS_MISALIGN_EN is defined.
module serv_dbus_lane
    import serv_dbus_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lsb,
    input  logic [31:0] dat,
    output logic [3:0]  sel,
    output logic [31:0] wdat,
    output logic        misalign
);

    // Lane select and replicated write data per access size
    always_comb begin
        sel  = 4'b1111;
        wdat = dat;
        case (size)
            SZ_BYTE: begin
                sel  = 4'b0001 << lsb;
                wdat = {4{dat[7:0]}};
            end
            SZ_HALF: begin
                sel  = lsb[1] ? 4'b1100 : 4'b0011;
                wdat = {2{dat[15:0]}};
            end
            SZ_WORD: begin
                sel  = 4'b1111;
                wdat = dat;
            end
            default: begin
                sel  = 4'b1111;
                wdat = dat;
            end
        endcase
    end

`ifdef SERV_DBUS_MISALIGN_EN
    assign misalign = ((size == SZ_WORD) & (|lsb)) | ((size == SZ_HALF) & lsb[0]);
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: rtl/serv_dbus_serdes.sv
// Bit-serial <-> 32-bit parallel data-bus adapter for SERV loads and stores.
// Define SERV_DBUS_MISALIGN_EN to block misaligned requests.
module serv_dbus_serdes
    import serv_dbus_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cnt_en,
    input  logic        i_init,
    input  logic        i_run,
    input  logic [4:0]  i_cnt,
    input  logic        i_dbus_cyc,
    input  logic        i_mem_cmd,
    input  logic        i_signed,
    input  logic        i_word,
    input  logic        i_half,
    input  logic [1:0]  i_lsb,
    input  logic        i_rs2,
    output logic        o_rd,
    output logic        o_misalign,
    output logic        o_rdy,
    output logic        o_cyc,
    output logic        o_we,
    output logic [3:0]  o_sel,
    output logic [31:0] o_dat,
    input  logic [31:0] i_dat,
    input  logic        i_ack
);

    dbus_state_t state_r;
    dbus_state_t state_nxt_s;
    logic        cyc_nxt_s;
    logic        rdy_nxt_s;
    logic [31:0] dat_r;
    logic        sbit_r;
    logic [1:0]  size_s;
    logic [5:0]  width_s;
    logic        misalign_s;
    logic        load_cap_s;
    logic        sbit_cap_s;

    assign size_s  = size_enc(i_word, i_half);
    assign width_s = size_width(size_s);

    serv_dbus_lane u_lane (
        .size     (size_s),
        .lsb      (i_lsb),
        .dat      (dat_r),
        .sel      (o_sel),
        .wdat     (o_dat),
        .misalign (misalign_s)
    );

    assign o_misalign = misalign_s;
    assign o_we       = o_cyc & i_mem_cmd;

    // Acks outside BUSY are stale and must not disturb the data register
    assign load_cap_s = (state_r == BUSY) & i_ack & ~i_mem_cmd;
    assign sbit_cap_s = i_run & i_cnt_en &
                        (((size_s == SZ_BYTE) & (i_cnt == 5'd7)) |
                         ((size_s == SZ_HALF) & (i_cnt == 5'd15)));

    // Bus FSM next state; WAIT absorbs the still-asserted request level
    always_comb begin
        state_nxt_s = state_r;
        cyc_nxt_s   = 1'b0;
        rdy_nxt_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_dbus_cyc & ~misalign_s) begin
                    state_nxt_s = BUSY;
                    cyc_nxt_s   = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (i_ack) begin
                    state_nxt_s = WAIT;
                    rdy_nxt_s   = 1'b1;
                end else begin
                    cyc_nxt_s   = 1'b1;
                end
            end
            WAIT: begin
                if (~i_dbus_cyc) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Bus FSM state and registered handshake outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= IDLE;
            o_cyc   <= 1'b0;
            o_rdy   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            o_cyc   <= cyc_nxt_s;
            o_rdy   <= rdy_nxt_s;
        end
    end

    // Shared data register: store deserialise, load capture, load serialise
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dat_r <= 32'd0;
        end else if (load_cap_s) begin
            dat_r <= i_dat >> {i_lsb, 3'b000};
        end else if (i_init & i_cnt_en) begin
            dat_r <= {i_rs2, dat_r[31:1]};
        end else if (i_run & i_cnt_en) begin
            dat_r <= {1'b0, dat_r[31:1]};
        end else begin
            dat_r <= dat_r;
        end
    end

    // Sign bit of a narrow load, taken as its top bit passes dat[0]
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sbit_r <= 1'b0;
        end else if (sbit_cap_s) begin
            sbit_r <= dat_r[0];
        end else begin
            sbit_r <= sbit_r;
        end
    end

    // Serial load bit with zero/sign extension above the access size
    always_comb begin
        if ({1'b0, i_cnt} < width_s) begin
            o_rd = dat_r[0];
        end else begin
            o_rd = i_signed & sbit_r;
        end
    end

endmodule

// File: tb/tb_serv_dbus_serdes.sv
// Scoreboard bench for serv_dbus_serdes: stimulus queues expectations, a monitor checks them.
module tb_serv_dbus_serdes;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_cnt_en = 1'b0;
    logic        i_init = 1'b0;
    logic        i_run = 1'b0;
    logic [4:0]  i_cnt = 5'd0;
    logic        i_dbus_cyc = 1'b0;
    logic        i_mem_cmd = 1'b0;
    logic        i_signed = 1'b0;
    logic        i_word = 1'b0;
    logic        i_half = 1'b0;
    logic [1:0]  i_lsb = 2'd0;
    logic        i_rs2 = 1'b0;
    logic [31:0] i_dat = 32'd0;
    logic        i_ack = 1'b0;
    logic        o_rd;
    logic        o_misalign;
    logic        o_rdy;
    logic        o_cyc;
    logic        o_we;
    logic [3:0]  o_sel;
    logic [31:0] o_dat;

    serv_dbus_serdes dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_cnt_en(i_cnt_en), .i_init(i_init),
        .i_run(i_run), .i_cnt(i_cnt), .i_dbus_cyc(i_dbus_cyc), .i_mem_cmd(i_mem_cmd),
        .i_signed(i_signed), .i_word(i_word), .i_half(i_half), .i_lsb(i_lsb),
        .i_rs2(i_rs2), .o_rd(o_rd), .o_misalign(o_misalign), .o_rdy(o_rdy),
        .o_cyc(o_cyc), .o_we(o_we), .o_sel(o_sel), .o_dat(o_dat),
        .i_dat(i_dat), .i_ack(i_ack)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
    } bus_t;

    bus_t        exp_bus[$];
    int          exp_len[$];
    logic [31:0] exp_rd[$];
    int          total = 0;
    int          bad = 0;
    int          exp_rdy = 0;
    int          seen_rdy = 0;
    int          cyc_rises = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    // Reference model: lane mask is size-many bytes at the naturally aligned offset
    function automatic logic [3:0] m_sel(input logic [1:0] sz, input logic [1:0] lsb);
        int nb;
        int off;
        nb  = (sz == 2'd2) ? 4 : (sz == 2'd1) ? 2 : 1;
        off = (sz == 2'd2) ? 0 : (sz == 2'd1) ? (int'(lsb) / 2) * 2 : int'(lsb);
        m_sel = 4'(((1 << nb) - 1) << off);
    endfunction

    function automatic logic [31:0] m_dat(input logic [1:0] sz, input logic [31:0] rs2);
        logic [31:0] b;
        logic [31:0] h;
        b = rs2 & 32'h0000_00FF;
        h = rs2 & 32'h0000_FFFF;
        if (sz == 2'd0) m_dat = b * 32'h0101_0101;
        else if (sz == 2'd1) m_dat = h * 32'h0001_0001;
        else m_dat = rs2;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [1:0] lsb,
                                           input logic sgn, input logic [31:0] rdat);
        logic [31:0] sh;
        logic [63:0] mask;
        int w;
        sh   = rdat >> (8 * int'(lsb));
        w    = 8 * (1 << sz);
        mask = (64'd1 << w) - 64'd1;
        m_load = sh & mask[31:0];
        if (sgn && sh[w-1]) m_load = m_load | ~mask[31:0];
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic run_txn(input logic cmd, input logic [1:0] sz, input logic sgn,
                           input logic [1:0] lsb, input logic [31:0] rs2,
                           input logic [31:0] rdat, input int waits, input int hold);
        bus_t e;
        i_mem_cmd = cmd;
        i_word    = (sz == 2'd2);
        i_half    = (sz == 2'd1);
        i_signed  = sgn;
        i_lsb     = lsb;
        if (cmd) begin
            i_init = 1'b1;
            i_cnt_en = 1'b1;
            for (int n = 0; n < 32; n++) begin
                i_cnt = n[4:0];
                i_rs2 = rs2[n];
                step();
            end
            i_init = 1'b0;
            i_cnt_en = 1'b0;
        end
        e.we  = cmd;
        e.sel = m_sel(sz, lsb);
        e.dat = m_dat(sz, rs2);
        exp_bus.push_back(e);
        exp_len.push_back(waits + 1);
        i_dbus_cyc = 1'b1;
        step();
        repeat (waits) step();
        i_ack = 1'b1;
        i_dat = rdat;
        step();
        i_ack = 1'b0;
        i_dat = $urandom;
        exp_rdy++;
        repeat (hold) step();
        i_dbus_cyc = 1'b0;
        step();
        if (!cmd) begin
            exp_rd.push_back(m_load(sz, lsb, sgn, rdat));
            i_run = 1'b1;
            i_cnt_en = 1'b1;
            for (int n = 0; n < 32; n++) begin
                i_cnt = n[4:0];
                step();
            end
            i_run = 1'b0;
            i_cnt_en = 1'b0;
        end
        step();
    endtask

    // Monitor: checks every bus cycle, ready pulse and reassembled load word
    bus_t        mon_e;
    logic        prev_cyc = 1'b0;
    logic        prev_rdy = 1'b0;
    int          len = 0;
    logic [31:0] rd_acc = 32'd0;
    initial begin
        forever begin
            @(negedge i_clk);
            if (o_cyc && !prev_cyc) begin
                cyc_rises++;
                len = 0;
                if (exp_bus.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_cyc actual=1 required=0");
                end else begin
                    mon_e = exp_bus.pop_front();
                    chk("we", {31'd0, o_we}, {31'd0, mon_e.we});
                    chk("sel", {28'd0, o_sel}, {28'd0, mon_e.sel});
                    if (mon_e.we) chk("wdat", o_dat, mon_e.dat);
                end
            end
            if (o_cyc) len++;
            if (!o_cyc && prev_cyc) begin
                if (exp_len.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL cyc_len_unexpected actual=%0d required=none", len);
                end else begin
                    chk("cyc_len", len, exp_len.pop_front());
                end
            end
            if (o_rdy) begin
                seen_rdy++;
                chk("rdy_width", {31'd0, prev_rdy}, 32'd0);
                chk("rdy_at_fall", {30'd0, prev_cyc, o_cyc}, 32'd2);
            end
            if (i_run && i_cnt_en) begin
                rd_acc[i_cnt] = o_rd;
                if (i_cnt == 5'd31) begin
                    if (exp_rd.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL load_unexpected actual=%h required=none", rd_acc);
                    end else begin
                        chk("load_word", rd_acc, exp_rd.pop_front());
                    end
                end
            end
            prev_cyc = o_cyc;
            prev_rdy = o_rdy;
        end
    end

    initial begin
        int rises;
        logic [1:0] sz;
        logic [1:0] lsb;
        i_mem_cmd = 1'b1;
        repeat (3) step();
        @(negedge i_clk);
        chk("rst_cyc", {31'd0, o_cyc}, 32'd0);
        chk("rst_rdy", {31'd0, o_rdy}, 32'd0);
        chk("rst_we", {31'd0, o_we}, 32'd0);
        chk("rst_rd", {31'd0, o_rd}, 32'd0);
        i_rst = 1'b0;
        step();

        run_txn(1'b1, 2'd2, 1'b0, 2'd0, 32'hDEAD_BEEF, 32'd0, 0, 0);
        run_txn(1'b1, 2'd0, 1'b0, 2'd2, 32'h0000_00A5, 32'd0, 1, 1);
        run_txn(1'b0, 2'd0, 1'b1, 2'd2, 32'd0, 32'h0080_0000, 0, 0);
        run_txn(1'b0, 2'd0, 1'b0, 2'd2, 32'd0, 32'h0080_0000, 2, 0);
        run_txn(1'b0, 2'd1, 1'b1, 2'd2, 32'd0, 32'h9234_5678, 3, 5);

        i_mem_cmd = 1'b0;
        i_word = 1'b0;
        i_half = 1'b1;
        i_lsb = 2'd1;
        #1;
`ifdef SERV_DBUS_MISALIGN_EN
        chk("misalign_flag", {31'd0, o_misalign}, 32'd1);
        rises = cyc_rises;
        i_dbus_cyc = 1'b1;
        repeat (10) step();
        chk("misalign_no_cyc", rises, cyc_rises);
        i_dbus_cyc = 1'b0;
        step();
`else
        chk("misalign_off", {31'd0, o_misalign}, 32'd0);
        rises = cyc_rises;
        run_txn(1'b0, 2'd2, 1'b0, 2'd2, 32'd0, 32'hCAFE_1234, 0, 0);
        chk("unaligned_issued", cyc_rises, rises + 1);
`endif

        i_mem_cmd = 1'b0;
        i_word = 1'b0;
        i_half = 1'b0;
        i_lsb = 2'd0;
        exp_bus.push_back('{we: 1'b0, sel: 4'b0001, dat: 32'd0});
        exp_len.push_back(2);
        i_dbus_cyc = 1'b1;
        step();
        step();
        i_rst = 1'b1;
        i_dbus_cyc = 1'b0;
        step();
        @(negedge i_clk);
        chk("rst_busy_cyc", {31'd0, o_cyc}, 32'd0);
        i_rst = 1'b0;
        step();
        i_ack = 1'b1;
        step();
        i_ack = 1'b0;
        @(negedge i_clk);
        chk("stale_ack_rdy", {31'd0, o_rdy}, 32'd0);
        step();

        for (int t = 0; t < 24; t++) begin
            sz  = 2'($urandom_range(0, 2));
            lsb = 2'($urandom_range(0, 3));
`ifdef SERV_DBUS_MISALIGN_EN
            if (sz == 2'd2) lsb = 2'd0;
            if (sz == 2'd1) lsb = lsb & 2'b10;
`endif
            run_txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), lsb,
                    $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        repeat (4) step();
        chk("rdy_count", seen_rdy, exp_rdy);
        chk("bus_left", exp_bus.size(), 0);
        chk("len_left", exp_len.size(), 0);
        chk("rd_left", exp_rd.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serv_dbus_serdes.md
# serv_dbus_serdes

Bit-serial ↔ 32-bit parallel data-bus adapter for SERV load/store instructions. It sits directly downstream of the core state sequencer and consumes its bus-cycle request, bit counter and phase signals.
- Store path: it deserialises rs2 into a word, lane-aligns it, and runs one bus transaction.
- Load path: it captures and aligns the load word, then serialises it back to the register file with zero- or sign-extension.
- Completion: it pulses a ready strobe back to the sequencer.

## Interface
Parameters: none.
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_cnt_en  in  1  serial bit phase active
- i_init  in  1  sequencer in INIT (stage one)
- i_run  in  1  sequencer in RUN (stage two)
- i_cnt  in  5  current serial bit index, 0..31
- i_dbus_cyc  in  1  sequencer bus request (level)
- i_mem_cmd  in  1  1 = store, 0 = load
- i_signed  in  1  sign-extend load
- i_word  in  1  word access
- i_half  in  1  halfword access; byte when i_word = i_half = 0
- i_lsb  in  2  address bits [1:0]
- i_rs2  in  1  serial store data, LSB first
- o_rd  out  1  serial load data, LSB first
- o_misalign  out  1  access misaligned for its size
- o_rdy  out  1  one-cycle transaction-complete strobe
- o_cyc  out  1  bus cycle
- o_we  out  1  bus write enable
- o_sel  out  4  byte-lane select
- o_dat  out  32  bus write data
- i_dat  in  32  bus read data
- i_ack  in  1  bus acknowledge

## Operation
Bus FSM has three states:
- IDLE: i_dbus_cyc & !o_misalign moves to BUSY and sets o_cyc.
- BUSY: holds o_cyc until i_ack. On i_ack it clears o_cyc, pulses o_rdy, and moves to WAIT.
- WAIT: stays until i_dbus_cyc = 0, then returns to IDLE. This prevents re-issuing while the sequencer still presents the request.

Data register dat[31:0]:
- Store capture: while i_init & i_cnt_en, dat <= {i_rs2, dat[31:1]}. After 32 bits, dat holds rs2.
- Load capture: on i_ack & !i_mem_cmd, dat <= i_dat >> (8*i_lsb).
- Load serialisation: while i_run & i_cnt_en, dat shifts right one bit per cycle.

Store data lane replication:
- byte: o_dat = {4{dat[7:0]}}
- half: o_dat = {2{dat[15:0]}}
- word: o_dat = dat

Byte-lane select:
- byte: o_sel = 4'b0001 << i_lsb
- half: o_sel = i_lsb[1] ? 4'b1100 : 4'b0011
- word: o_sel = 4'b1111

Other bus outputs:
- o_we = o_cyc & i_mem_cmd.

Load output:
- o_rd = dat[0] while i_cnt < size (8/16/32).
- Beyond size, o_rd = i_signed ? sbit : 0.
- sbit is registered from dat[0] when i_cnt == 7 (byte) or 15 (half).

Boundary conditions:
- i_ack in IDLE or WAIT is ignored.
- o_misalign = 1 never starts a transaction, even with i_dbus_cyc high.
- Reset mid-BUSY drops o_cyc in the next cycle. A later stale i_ack is ignored.
- Store capture and load serialisation never overlap, because i_init and i_run are exclusive.

## Timing
Reset values:
- FSM = IDLE
- o_cyc = 0, o_rdy = 0
- dat = 0, sbit = 0
- Hence o_we = 0 and o_rd = 0. o_dat, o_sel and o_misalign are combinational from inputs and dat.

Latencies:
- o_cyc rises 1 cycle after i_dbus_cyc is first sampled high in IDLE.
- o_cyc falls, and o_rdy is high, in the cycle after the i_ack edge. o_rdy lasts exactly 1 cycle.
- Zero-wait slave (ack in the first BUSY cycle): request to o_rdy = 2 cycles.

Load data:
- The load word is valid in dat from the o_rdy cycle onwards.
- o_rd bit n is presented in the cycle where i_cnt = n.

## Configuration
- SERV_DBUS_MISALIGN_EN defined: o_misalign computed as (i_word & |i_lsb) | (i_half & i_lsb[0]), and misaligned requests are blocked.
- SERV_DBUS_MISALIGN_EN undefined: o_misalign tied 0. All requests are issued, and lane logic uses i_lsb as given (a word at lsb = 2 gets o_sel = 4'b1111).

## Structure
- Package serv_dbus_pkg holds:
  - FSM state typedef (IDLE/BUSY/WAIT)
  - size encoding constants (SZ_BYTE/SZ_HALF/SZ_WORD)
  - size-to-bit-width constants (8/16/32)
- Sub-module serv_dbus_lane: combinational size/lsb → o_sel, o_dat replication and o_misalign. Instantiated once.

## Test plan
- Word store, rs2 = 0xDEADBEEF, lsb = 0:
  - 32 init bits, then i_dbus_cyc → o_cyc next cycle.
  - o_dat = 0xDEADBEEF, o_sel = 4'hF, o_we = 1.
  - ack → o_rdy 1 cycle.
- Byte store of 0xA5 at lsb = 2: o_dat = 0xA5A5A5A5, o_sel = 4'b0100.
- Signed byte load, i_dat = 0x00800000, lsb = 2: serial o_rd reassembles 0xFFFFFF80. With i_signed = 0 it gives 0x00000080.
- Half load at lsb = 1 (SERV_DBUS_MISALIGN_EN defined): o_misalign = 1, o_cyc never asserts over 10 cycles.
- Slave with 3 wait states:
  - o_cyc is held high 4 cycles.
  - o_rdy is a single pulse.
  - i_dbus_cyc held high afterwards causes no second cycle (FSM stays in WAIT).
- i_rst asserted during BUSY: o_cyc = 0 next cycle. A subsequent i_ack produces no o_rdy.
